// File: rtl/result_sampler.sv
// result_sampler: decimates the packed counter result word by DIV, buffers the
// decimated samples in a DEPTH-entry first-word-fall-through FIFO and presents
// them on a valid/ready stream. Samples that find the FIFO full (with no pop in
// the same cycle) are discarded and counted in a saturating 8-bit drop counter.
module result_sampler #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int DIV   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [7:0]       DROP_MAX = 8'hFF;

    logic [CNT_W-1:0] div_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic [7:0]       drop_q;
    logic [WIDTH-1:0] storage [DEPTH];

    logic tick;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // Sample strobes: a full FIFO still accepts a sample when the head leaves on
    // the same edge, because that edge frees the slot the sample is written into.
    always_comb begin
        tick = en && (div_cnt == CNT_MAX);
        full = (level_q == LVL_FULL);
        pop  = (level_q != '0) && out_ready;
        push = tick && (!full || pop);
        drop = tick && full && !pop;
    end

    // Decimation counter: advances only on enabled cycles, wraps after DIV-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (en) begin
            if (div_cnt == CNT_MAX) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CNT_W'(1);
            end
        end
    end

    // Sample storage: cleared by reset so the head reads zero while idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (push) begin
            storage[wr_ptr] <= data_in;
        end
    end

    // Read/write pointers wrap naturally; fullness comes from the level count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Occupancy: a push and pop on the same edge leave the level unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '0;
        end else if (push && !pop) begin
            level_q <= level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_q <= level_q - LVL_W'(1);
        end
    end

    // Drop counter: counts discarded samples and sticks at its maximum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= '0;
        end else if (drop && (drop_q != DROP_MAX)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    // Stream outputs come straight from registers, with no path from out_ready.
    always_comb begin
        out_data   = storage[rd_ptr];
        out_valid  = (level_q != '0);
        level      = level_q;
        drop_count = drop_q;
    end

endmodule

// File: tb/tb_result_sampler.sv
// tb_result_sampler: directed tests for result_sampler. The main instance uses
// DIV=4; a second instance with DIV=1 covers the tick-every-cycle case and the
// drop counter saturation.
module tb_result_sampler;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] data_in;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic [7:0]  drop_count;

    logic        en1;
    logic [15:0] data_in1;
    logic [15:0] out_data1;
    logic        out_valid1;
    logic        out_ready1;
    logic [2:0]  level1;
    logic [7:0]  drop_count1;

    int vectors;
    int miscompares;

    result_sampler #(.WIDTH(16), .DEPTH(4), .DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data_in    (data_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .drop_count (drop_count)
    );

    result_sampler #(.WIDTH(16), .DEPTH(4), .DIV(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en1),
        .data_in    (data_in1),
        .out_data   (out_data1),
        .out_valid  (out_valid1),
        .out_ready  (out_ready1),
        .level      (level1),
        .drop_count (drop_count1)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges with all inputs idle; returns 1 ns after an edge
    // with reset released, so the following cycle is cycle 0.
    task automatic do_reset();
        rst        = 1'b0;
        en         = 1'b0;
        out_ready  = 1'b0;
        data_in    = '0;
        en1        = 1'b0;
        out_ready1 = 1'b0;
        data_in1   = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Reset state and 20 idle cycles with en=0 while data_in is busy.
    task automatic test_reset();
        rst       = 1'b0;
        en        = 1'b0;
        out_ready = 1'b1;
        data_in   = 16'hFFFF;
        en1       = 1'b0;
        out_ready1 = 1'b0;
        data_in1  = '0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0 || drop_count !== 8'd0 || out_data !== 16'h0000) begin
            $display("[TB] FAIL reset_state got valid=%b level=%0d drops=%0d data=%h want 0 0 0 0000",
                     out_valid, level, drop_count, out_data);
            miscompares++;
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            data_in = 16'(16'hFFFF - c);
            step();
            vectors++;
            if (out_valid !== 1'b0 || level !== 3'd0 || drop_count !== 8'd0 || out_data !== 16'h0000) begin
                $display("[TB] FAIL idle_c%0d got valid=%b level=%0d drops=%0d data=%h want 0 0 0 0000",
                         c, out_valid, level, drop_count, out_data);
                miscompares++;
            end
        end
    endtask

    // DIV=4 with data_in = cycle index: samples 3, 7, 11, 15 each valid for one cycle.
    task automatic test_decimation();
        logic       exp_valid;
        logic [2:0] exp_level;
        do_reset();
        en        = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c <= 16; c++) begin
            data_in   = 16'(c);
            exp_valid = (c >= 4) && (c % 4 == 0);
            exp_level = exp_valid ? 3'd1 : 3'd0;
            vectors++;
            if (out_valid !== exp_valid || level !== exp_level) begin
                $display("[TB] FAIL decim_c%0d got valid=%b level=%0d want valid=%b level=%0d",
                         c, out_valid, level, exp_valid, exp_level);
                miscompares++;
            end
            if (exp_valid) begin
                vectors++;
                if (out_data !== 16'(c - 1)) begin
                    $display("[TB] FAIL decim_data_c%0d got %h want %h", c, out_data, 16'(c - 1));
                    miscompares++;
                end
            end
            step();
        end
        en        = 1'b0;
        out_ready = 1'b0;
    endtask

    // Six ticks into a stalled FIFO: four stored, two dropped, then drained in order.
    task automatic test_fill_and_drop();
        do_reset();
        en        = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 24; c++) begin
            data_in = 16'hA500 + 16'(c / 4);
            if (c == 16) begin
                vectors++;
                if (level !== 3'd4 || drop_count !== 8'd0) begin
                    $display("[TB] FAIL fill_c16 got level=%0d drops=%0d want 4 0", level, drop_count);
                    miscompares++;
                end
            end
            step();
        end
        en = 1'b0;
        vectors++;
        if (level !== 3'd4 || out_data !== 16'hA500 || drop_count !== 8'd2 || out_valid !== 1'b1) begin
            $display("[TB] FAIL fill_full got level=%0d head=%h drops=%0d valid=%b want 4 a500 2 1",
                     level, out_data, drop_count, out_valid);
            miscompares++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_data !== 16'hA500 + 16'(i) || level !== 3'(4 - i) || out_valid !== 1'b1) begin
                $display("[TB] FAIL drain_%0d got data=%h level=%0d valid=%b want %h %0d 1",
                         i, out_data, level, out_valid, 16'hA500 + 16'(i), 4 - i);
                miscompares++;
            end
            step();
        end
        vectors++;
        if (level !== 3'd0 || out_valid !== 1'b0 || drop_count !== 8'd2) begin
            $display("[TB] FAIL drain_empty got level=%0d valid=%b drops=%0d want 0 0 2",
                     level, out_valid, drop_count);
            miscompares++;
        end
        out_ready = 1'b0;
    endtask

    // Full FIFO where a tick coincides with a pop: no drop, new word enters tail.
    task automatic test_full_pop();
        do_reset();
        en        = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            data_in   = 16'hB000 + 16'(c / 4);
            out_ready = (c == 19);
            if (c == 16) begin
                vectors++;
                if (level !== 3'd4 || out_data !== 16'hB000) begin
                    $display("[TB] FAIL fullpop_pre got level=%0d head=%h want 4 b000", level, out_data);
                    miscompares++;
                end
            end
            step();
        end
        en        = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (level !== 3'd4 || drop_count !== 8'd0 || out_data !== 16'hB001) begin
            $display("[TB] FAIL fullpop_post got level=%0d drops=%0d head=%h want 4 0 b001",
                     level, drop_count, out_data);
            miscompares++;
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            vectors++;
            if (out_data !== 16'hB000 + 16'(i) || out_valid !== 1'b1) begin
                $display("[TB] FAIL fullpop_drain_%0d got data=%h valid=%b want %h 1",
                         i, out_data, out_valid, 16'hB000 + 16'(i));
                miscompares++;
            end
            step();
        end
        vectors++;
        if (level !== 3'd0 || drop_count !== 8'd0) begin
            $display("[TB] FAIL fullpop_end got level=%0d drops=%0d want 0 0", level, drop_count);
            miscompares++;
        end
        out_ready = 1'b0;
    endtask

    // DIV=1 instance: tick every cycle, fill, then 300 drops saturate at 255.
    task automatic test_saturation();
        do_reset();
        en1        = 1'b1;
        out_ready1 = 1'b0;
        for (int c = 0; c <= 304; c++) begin
            data_in1 = 16'h5A00 + 16'(c);
            if (c == 1) begin
                vectors++;
                if (level1 !== 3'd1 || out_valid1 !== 1'b1 || out_data1 !== 16'h5A00) begin
                    $display("[TB] FAIL div1_first got level=%0d valid=%b data=%h want 1 1 5a00",
                             level1, out_valid1, out_data1);
                    miscompares++;
                end
            end
            if (c == 4) begin
                vectors++;
                if (level1 !== 3'd4 || drop_count1 !== 8'd0) begin
                    $display("[TB] FAIL div1_full got level=%0d drops=%0d want 4 0", level1, drop_count1);
                    miscompares++;
                end
            end
            if (c == 258) begin
                vectors++;
                if (drop_count1 !== 8'd254) begin
                    $display("[TB] FAIL sat_254 got %0d want 254", drop_count1);
                    miscompares++;
                end
            end
            if (c == 259) begin
                vectors++;
                if (drop_count1 !== 8'd255) begin
                    $display("[TB] FAIL sat_255 got %0d want 255", drop_count1);
                    miscompares++;
                end
            end
            if (c == 304) begin
                vectors++;
                if (drop_count1 !== 8'd255 || level1 !== 3'd4 || out_data1 !== 16'h5A00) begin
                    $display("[TB] FAIL sat_hold got drops=%0d level=%0d head=%h want 255 4 5a00",
                             drop_count1, level1, out_data1);
                    miscompares++;
                end
            end
            step();
        end
        en1 = 1'b0;
    endtask

    // Reset pulled low between edges with level=3 and drop_count=5.
    task automatic test_async_reset();
        do_reset();
        en        = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 36; c++) begin
            data_in = 16'hD000 + 16'(c);
            step();
        end
        en        = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (level !== 3'd3 || drop_count !== 8'd5 || out_data !== 16'hD007) begin
            $display("[TB] FAIL async_pre got level=%0d drops=%0d head=%h want 3 5 d007",
                     level, drop_count, out_data);
            miscompares++;
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || level !== 3'd0 || drop_count !== 8'd0 || out_data !== 16'h0000) begin
            $display("[TB] FAIL async_clear got valid=%b level=%0d drops=%0d data=%h want 0 0 0 0000",
                     out_valid, level, drop_count, out_data);
            miscompares++;
        end
        step();
        rst = 1'b1;
        en  = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            data_in = 16'hC000 + 16'(c);
            vectors++;
            if (out_valid !== (c == 4)) begin
                $display("[TB] FAIL async_restart_c%0d got valid=%b want %b", c, out_valid, (c == 4));
                miscompares++;
            end
            if (c == 4) begin
                vectors++;
                if (out_data !== 16'hC003) begin
                    $display("[TB] FAIL async_restart_data got %h want c003", out_data);
                    miscompares++;
                end
            end
            step();
        end
        en = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_decimation();
        test_fill_and_drop();
        test_full_pop();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/result_sampler.md
# result_sampler

Downstream consumer of the 16-bit packed counter result word ({count_a, count_b}). Decimates the word by a programmable ratio, buffers samples in a small first-word-fall-through FIFO, and presents them on a valid/ready stream for a slower sink (trace port, bus bridge). Samples that arrive while the FIFO is full are dropped and counted.

## Interface
- WIDTH, 16, sample word width (matches packed result)
- DEPTH, 4, FIFO entries; power of two, >= 2
- DIV, 4, decimation ratio: one sample every DIV enabled cycles; >= 1
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (asserted at 0)
- en  input  1  sampling enable; decimation counter advances only when 1
- data_in  input  WIDTH  packed result word to sample
- out_data  output  WIDTH  FIFO head word; valid only when out_valid=1
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  sink accepts head this cycle
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
- drop_count  output  8  samples lost to full FIFO, saturating

## Operation
- Decimation counter div_cnt, range 0..DIV-1: increments when en=1, wraps DIV-1 -> 0; holds when en=0. Tick = en && (div_cnt == DIV-1). DIV=1: tick every enabled cycle.
- Pop = out_valid && out_ready. Head advances, level decrements.
- Push on tick: data_in written at write pointer if level < DEPTH, or if level == DEPTH and pop occurs in the same cycle (slot freed same edge; level stays DEPTH).
- Drop: tick with level == DEPTH and no pop -> sample discarded, drop_count += 1, saturates at 255 (no wrap).
- Simultaneous push and pop at any non-full level: level unchanged, both pointers advance.
- Pop with level 0 impossible (out_valid=0); out_ready ignored when empty.
- Pointers are log2(DEPTH) bits, wrap naturally; full/empty derived from level, not pointer equality.
- out_valid = (level != 0); out_data = storage[read pointer] (combinational read, registered storage).
- No flush input; only rst clears state.

## Timing
- Reset (rst=0, asynchronous, takes effect immediately): div_cnt=0, pointers=0, level=0, out_valid=0, drop_count=0, storage=0 so out_data=0. Deassertion synchronous to clk externally.
- Reset mid-operation: all buffered samples and drop_count lost; first tick after release occurs DIV enabled cycles after rst returns high.
- Latency: data_in sampled at the tick edge; out_valid=1 and out_data=that word from the following cycle (1 cycle) when FIFO was empty.
- Pop edge: next head visible the cycle after; out_valid falls same edge level reaches 0.
- out_data/out_valid depend only on registers (no combinational path from out_ready).
- level and drop_count update on the same edge as the push/pop/drop that changes them.

## Test plan
- Reset/idle: rst=0 then 1, en=0 for 20 cycles -> out_valid=0, level=0, drop_count=0, out_data=0 throughout.
- Decimation: DIV=4, en=1 from cycle 0, data_in = cycle index, out_ready=1 -> samples 3, 7, 11, 15 emitted, each out_valid for one cycle starting the cycle after its tick.
- Fill and drop: out_ready=0, en=1, data_in=16'hA500+n per tick, 6 ticks -> level=4, head=16'hA500, drop_count=2; then out_ready=1 -> outputs A500..A503 in order, level returns to 0.
- Full with simultaneous pop: level=4, tick coincides with pop -> no drop, level stays 4, new word enters tail, drop_count unchanged.
- Saturation: out_ready=0, DIV=1, 300 ticks after full -> drop_count=255 and holds.
- Async reset mid-stream: level=3, drop_count=5, pull rst low between edges -> all outputs zero immediately without a clock edge; after release, first sample appears after DIV enabled cycles.
